// File: rtl/normalization_pkg.sv
// normalization_pkg: widths and constants shared by the adder_tree, normalization and subnormal_handling stages.
package normalization_pkg;
    localparam int SUM_W     = 20;
    localparam int EXP_IN_W  = 6;
    localparam int EXP_OUT_W = 7;
    localparam int MAN_W     = 11;
    localparam logic [EXP_OUT_W-1:0] ZERO_EXP = 7'h40;
endpackage

// File: rtl/normalization_lzc20.sv
// lzc20: combinational leading-zero counter over 20 bits; returns 20 for an all-zero input.
module lzc20
    import normalization_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [4:0]       count
);
    always_comb begin
        count = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++)
            if (value[i]) count = 5'(SUM_W - 1 - i);
    end
endmodule

// File: rtl/normalization.sv
// normalization: post-adder normalize to sign / 11-bit magnitude / signed exponent, 1-cycle registered.
// Define NORMALIZATION_RNE_EN to round-to-nearest-even the magnitude instead of truncating.
module normalization
    import normalization_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [SUM_W-1:0]     signed_sum,
    input  logic [EXP_IN_W-1:0]  exp_max,
    output logic                 out_valid,
    output logic                 sign,
    output logic [MAN_W-1:0]     norm_sum,
    output logic [EXP_OUT_W-1:0] exp_final
);
    logic                 sgn;
    logic [SUM_W-1:0]     mag;
    logic [4:0]           lz;
    logic                 zero;
    logic [EXP_OUT_W-1:0] exp_raw;
    logic [MAN_W-1:0]     man_r;
    logic [EXP_OUT_W-1:0] exp_r;

    // 20-bit negate so that -2^19 yields 2^19 rather than overflowing
    assign sgn     = signed_sum[SUM_W-1];
    assign mag     = sgn ? -signed_sum : signed_sum;
    assign zero    = (mag == '0);
    assign exp_raw = {1'b0, exp_max} - {2'b00, lz};

    lzc20 u_lzc (.value(mag), .count(lz));

`ifdef NORMALIZATION_RNE_EN
    logic [SUM_W-1:0] shifted;
    logic [MAN_W-1:0] man;
    logic             guard;
    logic             sticky;
    logic [MAN_W:0]   man_inc;

    assign shifted = mag << lz;
    assign man     = shifted[SUM_W-1:SUM_W-MAN_W];
    assign guard   = shifted[SUM_W-MAN_W-1];
    assign sticky  = |shifted[SUM_W-MAN_W-2:0];
    assign man_inc = {1'b0, man} + {{MAN_W{1'b0}}, guard & (sticky | man[0])};
    assign man_r   = man_inc[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : man_inc[MAN_W-1:0];
    assign exp_r   = (man_inc[MAN_W] && exp_raw != 7'd63) ? exp_raw + 7'd1 : exp_raw;
`else
    assign man_r = MAN_W'((mag << lz) >> (SUM_W - MAN_W));
    assign exp_r = exp_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            norm_sum  <= '0;
            exp_final <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign      <= zero ? 1'b0 : sgn;
                norm_sum  <= zero ? '0 : man_r;
                exp_final <= zero ? ZERO_EXP : exp_r;
            end
        end
    end
endmodule

// File: tb/tb_normalization.sv
// tb_normalization: table-driven directed check of normalization, plus reset/hold sequences.
module tb_normalization;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [19:0] signed_sum = '0;
    logic [5:0]  exp_max = '0;
    logic        out_valid;
    logic        sign;
    logic [10:0] norm_sum;
    logic [6:0]  exp_final;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] sum;
        logic [5:0]  emax;
        logic        s;
        logic [10:0] n;
        logic [6:0]  e;
    } vec_t;

    vec_t vecs[10];

    normalization dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_sum(signed_sum),
        .exp_max(exp_max), .out_valid(out_valid), .sign(sign),
        .norm_sum(norm_sum), .exp_final(exp_final)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    task automatic apply(input logic [19:0] s_in, input logic [5:0] e_in);
        @(negedge clk);
        signed_sum = s_in;
        exp_max    = e_in;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic s, input logic [10:0] n, input logic [6:0] e);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".sign"}, 32'(sign), 32'(s));
        check({name, ".norm"}, 32'(norm_sum), 32'(n));
        check({name, ".exp"}, 32'(exp_final), 32'(e));
    endtask

    initial begin
        vecs[0] = '{20'h0001F, 6'd7,  1'b0, 11'b11111000000, 7'h78};
        vecs[1] = '{20'hFFFE0, 6'd10, 1'b1, 11'b10000000000, 7'h7C};
        vecs[2] = '{20'h80000, 6'd0,  1'b1, 11'b10000000000, 7'h00};
        vecs[3] = '{20'h00000, 6'd33, 1'b0, 11'b00000000000, 7'h40};
`ifdef NORMALIZATION_RNE_EN
        vecs[4] = '{20'h7FFFF, 6'd63, 1'b0, 11'b10000000000, 7'd63};
        vecs[5] = '{20'h00FFF, 6'd30, 1'b0, 11'b10000000000, 7'd23};
        vecs[6] = '{20'h00A07, 6'd12, 1'b0, 11'h504,         7'd4};
`else
        vecs[4] = '{20'h7FFFF, 6'd63, 1'b0, 11'b11111111111, 7'd62};
        vecs[5] = '{20'h00FFF, 6'd30, 1'b0, 11'b11111111111, 7'd22};
        vecs[6] = '{20'h00A07, 6'd12, 1'b0, 11'h503,         7'd4};
`endif
        vecs[7] = '{20'h00A05, 6'd12, 1'b0, 11'h502,         7'd4};
        vecs[8] = '{20'h00001, 6'd0,  1'b0, 11'b10000000000, 7'h6D};
        vecs[9] = '{20'hFFFFF, 6'd5,  1'b1, 11'b10000000000, 7'h72};

        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.sign", 32'(sign), 32'd0);
        check("rst.norm", 32'(norm_sum), 32'd0);
        check("rst.exp", 32'(exp_final), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].sum, vecs[i].emax);
            check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].n, vecs[i].e);
        end

        // idle cycle: valid drops, data holds last result
        @(posedge clk);
        #1;
        check("idle.valid", 32'(out_valid), 32'd0);
        check("idle.sign", 32'(sign), 32'd1);
        check("idle.norm", 32'(norm_sum), 32'h400);
        check("idle.exp", 32'(exp_final), 32'h72);

        // back-to-back valids with a one-cycle async reset between them
        apply(20'h0001F, 6'd7);
        check_out("pre_rst", 1'b0, 11'b11111000000, 7'h78);
        @(negedge clk);
        signed_sum = 20'hFFFE0;
        exp_max    = 6'd10;
        in_valid   = 1'b1;
        rst        = 1'b1;
        #1;
        check("async.valid", 32'(out_valid), 32'd0);
        check("async.sign", 32'(sign), 32'd0);
        check("async.norm", 32'(norm_sum), 32'd0);
        check("async.exp", 32'(exp_final), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("post_rst", 1'b1, 11'b10000000000, 7'h7C);
        @(posedge clk);
        #1;
        check("post_rst.drop", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/normalization.md
# normalization

Post-adder normalization stage of the SD4 MAC datapath. It takes the 20-bit two's-complement sum from the adder tree and the shared maximum exponent from alignment. It produces sign, an 11-bit left-justified magnitude (hidden one at the MSB) and a signed 7-bit exponent. All outputs are registered for the downstream subnormal-handling / packing stage.

## Interface
- Parameters: none. Widths come from the shared package.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies signed_sum / exp_max this cycle.
- signed_sum  in  20  two's-complement adder-tree result.
- exp_max  in  6  unsigned maximum exponent of the aligned partial products.
- out_valid  out  1  registered; high one cycle after an accepted input.
- sign  out  1  sign of signed_sum (bit 19).
- norm_sum  out  11  normalized magnitude; bit 10 is the leading one (0 for zero input).
- exp_final  out  7  two's-complement result exponent.

## Operation
- Interface note: one clock; reset is asynchronous and active-high.
- sign = signed_sum[19].
- Magnitude is computed as mag = sign ? -signed_sum : signed_sum, held 20 bits wide so that -2^19 gives mag = 2^19 without overflow.
- lzc = number of leading zeros of mag over bits 19..0, range 0..19, or 20 when mag = 0.
- Shifted value: mag << lzc, then take bits 19..9 as norm_sum. Vacated low bits are zero-filled.
- exp_final = exp_max − lzc, computed in 7-bit signed arithmetic. Range is −19..63, so it never wraps.
- Zero input (mag = 0): sign = 0, norm_sum = 0, exp_final = 7'b1000000 (−64). This is the flush-to-zero marker for the downstream stage.
- Dropped bits after normalization (bits 8..0 of the shifted value) are truncated unless rounding is compiled in (see Configuration).

## Timing
- Latency is 1 cycle. Inputs are sampled on the clk edge when in_valid = 1, and results appear on the following edge with out_valid = 1.
- When in_valid = 0, the data outputs hold their last value and out_valid drops to 0 on the next edge.
- There is no backpressure; a new input may be accepted every cycle.
- Reset values: out_valid = 0, sign = 0, norm_sum = 0, exp_final = 0. Reset applies immediately and asynchronously.
- Reset asserted mid-operation discards any in-flight result. The first valid after reset release follows normal latency.

## Configuration
- NORMALIZATION_RNE_EN defined: round-to-nearest-even on the 11-bit result.
  - guard = shifted bit 8; sticky = OR of bits 7..0; lsb = norm_sum[0].
  - Increment when guard & (sticky | lsb).
  - On mantissa carry-out, norm_sum = 11'b10000000000 and exp_final is incremented, saturating at 63.
- NORMALIZATION_RNE_EN undefined: truncation only, with no exponent adjustment.

## Structure
- Package normalization_pkg holds:
  - SUM_W = 20, EXP_IN_W = 6, EXP_OUT_W = 7, MAN_W = 11.
  - ZERO_EXP = 7'h40.
  - Shared with the adder_tree and subnormal_handling stages.
- One sub-module: lzc20, a combinational 20-bit leading-zero counter with a 5-bit count output (20 when input is zero).
- Output register and the optional rounding logic live in the top module.

## Test plan
- signed_sum = 20'h0001F, exp_max = 6'd7 -> sign 0, norm_sum 11'b11111000000, exp_final 7'b1111000 (−8), out_valid one cycle later.
- signed_sum = 20'hFFFE0 (−32), exp_max = 6'd10 -> sign 1, norm_sum 11'b10000000000, exp_final 7'b1111100 (−4).
- signed_sum = 20'h80000 (−2^19), exp_max = 6'd0 -> sign 1, norm_sum 11'b10000000000, exp_final 0.
- signed_sum = 0, exp_max = 6'd33 -> sign 0, norm_sum 0, exp_final 7'b1000000.
- signed_sum = 20'h7FFFF, exp_max = 6'd63:
  - without the macro -> norm_sum 11'b11111111111, exp_final 7'd62.
  - with NORMALIZATION_RNE_EN -> norm_sum 11'b10000000000, exp_final 7'd63.
- Assert rst for one cycle between two back-to-back valid inputs -> outputs and out_valid are 0 immediately; the post-release input completes with 1-cycle latency.
